enigma_result_buffer: RTL and testbench

Receive-side companion to the Enigma input feeder. Captures encoded symbols from the Enigma core output (6-bit codes, 1..26 = A..Z) into a 16-entry result RAM. Counts accepted and rejected symbols and stops after the programmed message length. Exposes a registered-address read port so the host can retrieve the ciphertext after `done_o`.

---
 rtl/enigma_result_buffer.sv | 108 ++++++++++
 tb/tb_enigma_result_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/enigma_result_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | enigma_result_buffer                                                       |
// | Captures validated Enigma output symbols into a small result RAM.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module enigma_result_buffer #(
  parameter int SYMB_W = 6,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] symb_numb,
  input  logic [SYMB_W-1:0] output_s,
  input  logic              output_valid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] wr_cnt_o,
  output logic [ADDR_W-1:0] err_cnt_o,
  input  logic [ADDR_W-1:0] rr_addr_i,
  output logic [SYMB_W-1:0] rr_data_o
);

  localparam logic [SYMB_W-1:0] SYM_MIN = SYMB_W'(1);
  localparam logic [SYMB_W-1:0] SYM_MAX = SYMB_W'(26);
  localparam logic [ADDR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] len_q, len_nxt;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_nxt;
  logic [ADDR_W-1:0] err_cnt_q, err_cnt_nxt;
  logic [ADDR_W-1:0] wr_inc;
  logic              wr_en;
  logic              sym_ok;

  logic [SYMB_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr_q;

  assign sym_ok = (output_s >= SYM_MIN) && (output_s <= SYM_MAX);
  assign wr_inc = wr_cnt_q + ADDR_W'(1);

  always_comb begin
    state_nxt   = state;
    len_nxt     = len_q;
    wr_cnt_nxt  = wr_cnt_q;
    err_cnt_nxt = err_cnt_q;
    wr_en       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_i) begin
          len_nxt     = symb_numb;
          wr_cnt_nxt  = '0;
          err_cnt_nxt = '0;
          state_nxt   = (symb_numb == '0) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        // A restart request is ignored here; only reset aborts a capture.
        if (output_valid_i) begin
          if (sym_ok) begin
            wr_en      = 1'b1;
            wr_cnt_nxt = wr_inc;
            if (wr_inc == len_q) state_nxt = DONE;
          end else if (err_cnt_q != ERR_MAX) begin
            err_cnt_nxt = err_cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      len_q     <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state     <= state_nxt;
      len_q     <= len_nxt;
      wr_cnt_q  <= wr_cnt_nxt;
      err_cnt_q <= err_cnt_nxt;
    end
  end

  // RAM and read-address register are deliberately outside reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_cnt_q] <= output_s;
    rd_addr_q <= rr_addr_i;
  end

  assign rr_data_o = mem[rd_addr_q];
  assign busy_o    = (state == CAPTURE);
  assign done_o    = (state == DONE);
  assign wr_cnt_o  = wr_cnt_q;
  assign err_cnt_o = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_enigma_result_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_enigma_result_buffer                                                    |
// | Self-checking bench for the Enigma result buffer.                         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_enigma_result_buffer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic [3:0] symb_numb = '0;
  logic [5:0] output_s = '0;
  logic       output_valid_i = 1'b0;
  logic       busy_o, done_o;
  logic [3:0] wr_cnt_o, err_cnt_o;
  logic [3:0] rr_addr_i = '0;
  logic [5:0] rr_data_o;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 capturing, 2 done
  int         m_state = 0;
  int         m_len = 0, m_wr = 0, m_err = 0;
  logic [5:0] m_mem [16];

  enigma_result_buffer #(.SYMB_W(6), .DEPTH(16), .ADDR_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .symb_numb(symb_numb),
    .output_s(output_s), .output_valid_i(output_valid_i), .busy_o(busy_o),
    .done_o(done_o), .wr_cnt_o(wr_cnt_o), .err_cnt_o(err_cnt_o),
    .rr_addr_i(rr_addr_i), .rr_data_o(rr_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Apply one cycle of inputs, advance the model by the stated rules, sample #1 after the edge.
  task automatic cyc(input bit st, input int n, input bit v, input int s, input bit rst = 1'b0);
    logic [31:0] nv;
    nv = n;
    rst_i = rst; start_i = st; symb_numb = nv[3:0];
    output_valid_i = v; output_s = 6'(s);
    if (rst) begin
      m_state = 0; m_wr = 0; m_err = 0; m_len = 0;
    end else if (m_state != 1 && st) begin
      m_len = n; m_wr = 0; m_err = 0;
      m_state = (n == 0) ? 2 : 1;
    end else if (m_state == 1 && v) begin
      if (s >= 1 && s <= 26) begin
        m_mem[m_wr] = 6'(s);
        m_wr++;
        if (m_wr == m_len) m_state = 2;
      end else if (m_err < 15) begin
        m_err++;
      end
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0; start_i = 1'b0; output_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 5, 1);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
    checks++; if (wr_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_wr: got %0d want 0", wr_cnt_o); end
    checks++; if (err_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", err_cnt_o); end
  endtask

  task automatic test_basic();
    int syms [3] = '{5, 12, 26};
    cyc(1, 3, 0, 0);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy_o); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, syms[i]);
      checks++; if (wr_cnt_o !== 4'(i + 1)) begin errors++; $display("FAIL basic_wr%0d: got %0d want %0d", i, wr_cnt_o, i + 1); end
      checks++; if (done_o !== (i == 2)) begin errors++; $display("FAIL basic_done%0d: got %b want %b", i, done_o, i == 2); end
    end
    checks++; if (err_cnt_o !== 4'd0) begin errors++; $display("FAIL basic_err: got %0d want 0", err_cnt_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy_o); end
    for (int a = 0; a < 3; a++) begin
      rr_addr_i = 4'(a);
      cyc(0, 0, 0, 0);
      checks++; if (rr_data_o !== 6'(syms[a])) begin errors++; $display("FAIL basic_rd%0d: got %0d want %0d", a, rr_data_o, syms[a]); end
    end
  endtask

  task automatic test_errors();
    int syms [5] = '{0, 27, 63, 1, 2};
    cyc(1, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) cyc(0, 0, 0, 0);
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL err_done_early%0d: got %b want 0", i, done_o); end
      cyc(0, 0, 1, syms[i]);
    end
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL err_done: got %b want 1", done_o); end
    checks++; if (err_cnt_o !== 4'd3) begin errors++; $display("FAIL err_cnt: got %0d want 3", err_cnt_o); end
    checks++; if (wr_cnt_o !== 4'd2) begin errors++; $display("FAIL err_wr: got %0d want 2", wr_cnt_o); end
    for (int a = 0; a < 2; a++) begin
      rr_addr_i = 4'(a);
      cyc(0, 0, 0, 0);
      checks++; if (rr_data_o !== 6'(a + 1)) begin errors++; $display("FAIL err_rd%0d: got %0d want %0d", a, rr_data_o, a + 1); end
    end
  endtask

  task automatic test_zero_len();
    cyc(1, 0, 1, 7);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy_o); end
    cyc(0, 0, 1, 7);
    checks++; if (wr_cnt_o !== 4'd0) begin errors++; $display("FAIL zero_wr: got %0d want 0", wr_cnt_o); end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b1) begin errors++; $display("FAIL zero_state: got busy=%b done=%b want busy=0 done=1", busy_o, done_o); end
  endtask

  task automatic test_saturate();
    cyc(1, 15, 0, 0);
    for (int i = 0; i < 20; i++) cyc(i == 10, 3, 1, 40);
    checks++; if (err_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_err: got %0d want 15", err_cnt_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL sat_busy: got %b want 1", busy_o); end
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 9);
    checks++; if (wr_cnt_o !== 4'd15 || done_o !== 1'b1) begin errors++; $display("FAIL sat_end: got wr=%0d done=%b want wr=15 done=1", wr_cnt_o, done_o); end
    cyc(0, 0, 1, 11);
    checks++; if (wr_cnt_o !== 4'd15 || err_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_frozen: got wr=%0d err=%0d want 15/15", wr_cnt_o, err_cnt_o); end
    for (int a = 0; a < 15; a++) begin
      rr_addr_i = 4'(a);
      cyc(0, 0, 0, 0);
      checks++; if (rr_data_o !== 6'd9) begin errors++; $display("FAIL sat_rd%0d: got %0d want 9", a, rr_data_o); end
    end
  endtask

  task automatic test_midreset();
    cyc(1, 4, 0, 0);
    cyc(0, 0, 1, 20);
    cyc(0, 0, 1, 21);
    cyc(0, 0, 1, 22, 1);
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || wr_cnt_o !== 4'd0) begin
      errors++; $display("FAIL midrst_state: got busy=%b done=%b wr=%0d want 0/0/0", busy_o, done_o, wr_cnt_o); end
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 4);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b want 1", done_o); end
    rr_addr_i = 4'd0;
    cyc(0, 0, 0, 0);
    checks++; if (rr_data_o !== 6'd4) begin errors++; $display("FAIL midrst_rd0: got %0d want 4", rr_data_o); end
  endtask

  task automatic test_restart();
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 50);
    cyc(0, 0, 1, 3);
    checks++; if (done_o !== 1'b1 || err_cnt_o !== 4'd1) begin errors++; $display("FAIL restart_pre: got done=%b err=%0d want 1/1", done_o, err_cnt_o); end
    cyc(1, 1, 0, 0);
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL restart_state: got done=%b busy=%b want 0/1", done_o, busy_o); end
    checks++; if (wr_cnt_o !== 4'd0 || err_cnt_o !== 4'd0) begin errors++; $display("FAIL restart_cnt: got wr=%0d err=%0d want 0/0", wr_cnt_o, err_cnt_o); end
    cyc(0, 0, 1, 8);
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int len, cycles, s, addr;
      bit v;
      len = $urandom_range(1, 15);
      cyc(1, len, 1, 5);
      cycles = 0;
      while (m_state == 1 && cycles < 200) begin
        v = ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(1, 26);
        addr = m_wr;
        rr_addr_i = 4'(addr);
        cyc($urandom_range(0, 7) == 0, $urandom_range(0, 15), v, s);
        cycles++;
        checks++;
        if (wr_cnt_o !== 4'(m_wr) || err_cnt_o !== 4'(m_err) || busy_o !== (m_state == 1) || done_o !== (m_state == 2)) begin
          errors++;
          $display("FAIL rand_status it%0d: got wr=%0d err=%0d busy=%b done=%b want wr=%0d err=%0d busy=%b done=%b",
                   it, wr_cnt_o, err_cnt_o, busy_o, done_o, m_wr, m_err, m_state == 1, m_state == 2);
        end
        checks++;
        if (rr_data_o !== m_mem[addr]) begin
          errors++; $display("FAIL rand_rd it%0d addr%0d: got %0d want %0d", it, addr, rr_data_o, m_mem[addr]);
        end
      end
      checks++;
      if (m_state != 2 || done_o !== 1'b1) begin
        errors++; $display("FAIL rand_timeout it%0d: got done=%b want 1 within 200 cycles", it, done_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_zero_len();
    test_saturate();
    test_midreset();
    test_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
